// File: rtl/vis_pkg.sv
// Shared definitions for the visibility run controller: state encoding and
// default widths derived from the accumulator geometry.
package vis_pkg;

    localparam int ACCUM     = 32;
    localparam int SBITS     = 7;
    localparam int VIS_CBITS = ACCUM - SBITS + 1;
    localparam int VIS_FBITS = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_STOP = 2'd3
    } vis_state_e;

endpackage

// File: rtl/vis_control.sv
// Frame-level run controller between the accumulator and the output AFIFO.
// Forwards whole frames only, for a host-requested number of frames (0 means
// run until stopped). Data path is combinational; control and status are
// registered.
module vis_control
    import vis_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CBITS = VIS_CBITS,
    parameter int FBITS = VIS_FBITS
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [CBITS-1:0] cfg_count_i,
    input  logic [FBITS-1:0] cfg_frames_i,
    input  logic             stop_i,
    input  logic             abort_i,
    output logic [CBITS-1:0] acc_count_o,
    input  logic             s_tvalid_i,
    input  logic             s_tlast_i,
    input  logic [WIDTH-1:0] s_tdata_i,
    output logic             s_tready_o,
    output logic             m_tvalid_o,
    output logic             m_tlast_o,
    output logic [WIDTH-1:0] m_tdata_o,
    input  logic             m_tready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [FBITS-1:0] frames_o,
    output logic             overflow_o
);

    // Frame counter saturates at all-ones rather than wrapping.
    function automatic logic [FBITS-1:0] sat_inc(input logic [FBITS-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    vis_state_e       state_q, state_d;
    logic             sof_q;
    logic             stop_pend_q, stop_pend_d;
    logic [FBITS-1:0] target_q, target_d;
    logic [FBITS-1:0] frames_q, frames_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;
    logic [CBITS-1:0] acc_count_q, acc_count_d;

    logic             fwd;
    logic             fwd_beat;
    logic             frame_end;

    // Forward in RUN, or in ARM once the incoming beat opens a new frame.
    assign fwd       = (state_q == ST_RUN) | ((state_q == ST_ARM) & sof_q);
    assign fwd_beat  = s_tvalid_i & fwd;
    assign frame_end = fwd_beat & m_tready_i & s_tlast_i;

    assign m_tvalid_o  = fwd_beat;
    assign m_tlast_o   = s_tlast_i;
    assign m_tdata_o   = s_tdata_i;
    assign s_tready_o  = fwd ? m_tready_i : 1'b1;
    assign cfg_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;
    assign frames_o    = frames_q;
    assign overflow_o  = overflow_q;
    assign acc_count_o = acc_count_q;

    // Frame-boundary tracker; the accumulator cannot stall, so every
    // presented beat counts whether or not it is accepted downstream.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sof_q <= 1'b1;
        end else if (s_tvalid_i) begin
            sof_q <= s_tlast_i;
        end
    end

    // Next-state, counter and status logic; abort beats frame-end beats stop.
    always_comb begin
        state_d     = state_q;
        stop_pend_d = stop_pend_q;
        target_d    = target_q;
        frames_d    = frames_q;
        acc_count_d = acc_count_q;
        done_d      = 1'b0;
        overflow_d  = overflow_q | (s_tvalid_i & ~s_tready_o);

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_valid_i) begin
                    state_d     = ST_ARM;
                    acc_count_d = cfg_count_i;
                    target_d    = cfg_frames_i;
                    frames_d    = '0;
                    overflow_d  = 1'b0;
                    stop_pend_d = 1'b0;
                end
            end
            ST_ARM, ST_RUN: begin
                if (abort_i) begin
                    state_d     = ST_STOP;
                    stop_pend_d = 1'b0;
                end else if (frame_end) begin
                    frames_d = sat_inc(frames_q);
                    if (((target_q != '0) && (frames_d == target_q)) ||
                        stop_pend_q || stop_i) begin
                        state_d     = ST_IDLE;
                        done_d      = 1'b1;
                        stop_pend_d = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (fwd_beat) begin
                    // A frame has started; a stop now waits for its end.
                    state_d = ST_RUN;
                    if (stop_i) begin
                        stop_pend_d = 1'b1;
                    end
                end else if (stop_i) begin
                    if (state_q == ST_ARM) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_pend_d = 1'b1;
                    end
                end
            end
            ST_STOP: begin
                // Drain to the end of the input frame to resynchronise.
                if (s_tvalid_i & s_tlast_i) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and status registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            stop_pend_q <= 1'b0;
            target_q    <= '0;
            frames_q    <= '0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
            acc_count_q <= '0;
        end else begin
            state_q     <= state_d;
            stop_pend_q <= stop_pend_d;
            target_q    <= target_d;
            frames_q    <= frames_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
            acc_count_q <= acc_count_d;
        end
    end

endmodule

// File: doc/vis_control.md
# vis_control

Frame-level run controller between the final-stage `accumulator` and the output AFIFO, on `vis_clock`. It holds the accumulation-count configuration and passes visibility beats downstream only for a host-requested number of whole frames. It aligns capture to frame boundaries, stops cleanly on request or abort, and reports busy, done, frame count and sticky overflow status.

## Interface
- `WIDTH`, 64: data width of the visibility beat, `{revis, imvis}`.
- `CBITS`, 26: width of the accumulation count (`ACCUM - SBITS + 1`).
- `FBITS`, 16: width of the frame counter.
- `clock`  in  1: correlator clock (`vis_clock`).
- `reset_n`  in  1: reset, synchronous and active-low.
- `cfg_valid_i`  in  1: start request.
- `cfg_ready_o`  out  1: high only in IDLE.
- `cfg_count_i`  in  CBITS: accumulation count, latched on start.
- `cfg_frames_i`  in  FBITS: frames to capture; 0 means continuous.
- `stop_i`  in  1: graceful stop, taking effect at the next frame end.
- `abort_i`  in  1: immediate stop.
- `acc_count_o`  out  CBITS: drives the accumulator `count_i`.
- `s_tvalid_i`, `s_tlast_i`, `s_tdata_i[WIDTH-1:0]`  in; `s_tready_o`  out: stream from the accumulator.
- `m_tvalid_o`, `m_tlast_o`, `m_tdata_o[WIDTH-1:0]`  out; `m_tready_i`  in: stream to the AFIFO.
- `busy_o`  out  1: high when not IDLE.
- `done_o`  out  1: one-cycle pulse on run completion.
- `frames_o`  out  FBITS: frames forwarded in the current or last run.
- `overflow_o`  out  1: sticky; cleared on start.

## Operation
- **States:** IDLE, ARM, RUN, STOP.
- **IDLE:**
  - On `cfg_valid_i` (with `cfg_ready_o` high): latch `cfg_count_i` into `acc_count_o`, latch `cfg_frames_i` as the target, clear `frames_o` and `overflow_o`, go to ARM.
- **Start-of-frame flag `sof`:**
  - Set to 1 at reset.
  - Set by an input beat with `s_tlast_i` high.
  - Cleared by any other input beat.
  - Tracked in every state.
- **ARM:**
  - Beats are dropped.
  - The first input beat with `sof` high is forwarded, and the state moves to RUN in the same cycle (`fwd` is combinational on state and `sof`).
- **RUN:**
  - All beats are forwarded.
  - Each handshaked `m_tlast_o` beat increments `frames_o`, saturating at all-ones.
  - When that increment reaches a nonzero target, or a stop is pending: go to IDLE and pulse `done_o`.
- **Stop:**
  - `stop_i` sets a pending flag, valid in ARM or RUN.
  - A stop in ARM returns to IDLE immediately and pulses `done_o`.
- **Abort:**
  - `abort_i` in any non-IDLE state goes to STOP.
  - STOP drops beats until an input `s_tlast_i` beat is accepted, then goes to IDLE and pulses `done_o`.
  - This resynchronises `sof`. The partially forwarded frame ends without `m_tlast_o`; the host discards it.
- **Forwarding path:**
  - `m_tvalid_o = s_tvalid_i & fwd`.
  - `m_tdata_o` and `m_tlast_o` pass through.
  - `s_tready_o = fwd ? m_tready_i : 1`; dropped beats are always accepted.
- **Overflow:**
  - `overflow_o` sets on any cycle with `s_tvalid_i & ~s_tready_o`, because the accumulator cannot stall.
  - It is cleared only by the next start.
- **Precedence:** abort > frame-end > stop. A `stop_i` arriving in the same cycle as a frame-final `tlast` ends the run at that beat.
- `acc_count_o` holds its value in IDLE and is never changed mid-run.

## Timing
- Data path latency is 0 cycles; it is combinational.
- State, counters and status are registered. `frames_o` updates the cycle after the `tlast` handshake.
- `done_o` is asserted the cycle after the terminating handshake or event, for exactly one cycle.
- `cfg_ready_o` is high in IDLE; a new start can be accepted the cycle after `done_o`.
- **Reset values:**
  - `acc_count_o` = 0.
  - `frames_o` = 0.
  - `overflow_o`, `done_o`, `busy_o` = 0.
  - `m_tvalid_o` = 0.
  - `s_tready_o` = 1.
  - `cfg_ready_o` = 1.
  - State IDLE, `sof` = 1.
- **Reset mid-run:** returns to IDLE the next cycle with no `done_o` pulse. Downstream may see a truncated frame.

## Structure
- Shared package `vis_pkg`: state encoding (`ST_IDLE`, `ST_ARM`, `ST_RUN`, `ST_STOP`), plus `CBITS` and `FBITS` defaults derived from `ACCUM` and `SBITS`.
- Single flat module, no sub-modules; the frame counter is inline.

## Test plan
- **Finite run:** frames=3, count=5, continuous 4-beat frames, idle bus start.
  - Exactly 12 beats forwarded with 3 `m_tlast_o`.
  - `frames_o` = 3; `done_o` pulses once.
  - `acc_count_o` = 5 throughout.
- **Mid-frame start:** start issued during beat 2 of a 4-beat frame.
  - Beats 2–4 are dropped; forwarding begins at the next frame's beat 1.
- **Graceful stop:** frames=0 (continuous); `stop_i` during frame 2.
  - Frame 2 is forwarded complete; `frames_o` = 2; then IDLE.
  - Frame 3 is dropped.
- **Abort:** `abort_i` at beat 2 of frame 1.
  - No further `m_tvalid_o`.
  - `done_o` pulses after the input `tlast`.
  - A subsequent start aligns to the next frame.
- **Overflow:** hold `m_tready_i` low for 2 beats in RUN.
  - `overflow_o` goes to 1 and stays 1 through IDLE.
  - It is cleared by the next `cfg_valid_i`.
- **Simultaneous stop and last:** `stop_i` coincides with frame 1's `tlast` handshake.
  - Run ends with `frames_o` = 1; `done_o` pulses the next cycle.
